// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment read-back path.
//   SEG_BLANK : all segments off (active-low)
//   SEG_CODE  : legal active-low {g,f,e,d,c,b,a} codes, indexed by digit 0-9
//   scan_state_e : stable-pattern FSM states
package seg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [9:0][6:0] SEG_CODE = {
    7'b0011000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

  typedef enum logic {WAIT_STABLE, HOLD} scan_state_e;

endpackage

// File: rtl/seg_to_bcd.sv
// Combinational seven-segment pattern to BCD decoder.
//   seg     : active-low pattern, {g,f,e,d,c,b,a}
//   digit   : decoded value 0-9, 4'hF when the pattern is not a legal code
//   illegal : pattern matches none of the ten legal codes
module seg_to_bcd
  import seg_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] digit,
  output logic       illegal
);

  always_comb begin
    digit   = 4'hF;
    illegal = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (seg == SEG_CODE[i]) begin
        digit   = 4'(i);
        illegal = 1'b0;
      end
    end
  end

endmodule

// File: rtl/segment_scan_reader.sv
// Reads back a multiplexed active-low seven-segment bus and rebuilds the
// BCD frame it displays. One evaluation per stable interval of the bus.
//   clk, reset  : clock, async active-high reset
//   anodes      : active-low digit strobes (bit 0 = rightmost digit)
//   segments    : active-low segment lines {g,f,e,d,c,b,a}
//   value       : recovered frame, value[4k+3:4k] = digit k
//   digit_error : per-digit illegal-pattern flag for the last frame
//   frame_valid : one-cycle pulse when value/digit_error update
module segment_scan_reader
  import seg_pkg::*;
#(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DIGITS-1:0]     anodes,
  input  logic [6:0]            segments,
  output logic [4*DIGITS-1:0]   value,
  output logic [DIGITS-1:0]     digit_error,
  output logic                  frame_valid
);

  localparam int SW = DIGITS + 7;
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int LW = $clog2(DIGITS + 1);
  localparam logic [SW-1:0] IDLE = {{DIGITS{1'b1}}, SEG_BLANK};

  logic [SW-1:0]            sync1, sync2, prev;
  logic [CW-1:0]            cnt;
  logic                     match, cnt_hit, eval, capture;
  scan_state_e              state, state_nxt;
  logic [IW-1:0]            idx;
  logic [LW-1:0]            low_cnt;
  logic [3:0]               dec_digit;
  logic                     dec_illegal;
  logic [DIGITS-1:0][3:0]   slots;
  logic [DIGITS-1:0]        err, seen;
  logic                     seen_full;

  // 2-flop synchronizer followed by the previous-sample register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= IDLE;
      sync2 <= IDLE;
      prev  <= IDLE;
    end else begin
      sync1 <= {anodes, segments};
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign match = (sync2 == prev);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                          cnt <= '0;
    else if (!match)                    cnt <= '0;
    else if (cnt != CW'(STABLE_CYCLES)) cnt <= cnt + 1'b1;
  end

  // The match that lifts the counter to STABLE_CYCLES is the evaluation
  // point, so the capture lands on the same edge the counter saturates.
  assign cnt_hit = match && (cnt == CW'(STABLE_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= WAIT_STABLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      WAIT_STABLE: if (cnt_hit) state_nxt = HOLD;
      HOLD:        if (!match)  state_nxt = WAIT_STABLE;
      default:     state_nxt = WAIT_STABLE;
    endcase
  end

  always_comb begin
    eval = (state == WAIT_STABLE) && cnt_hit;
  end

  // Exactly one anode low selects the digit; blanking and ghosting are ignored
  always_comb begin
    low_cnt = '0;
    idx     = '0;
    for (int k = 0; k < DIGITS; k++) begin
      if (!sync2[7+k]) begin
        low_cnt = low_cnt + 1'b1;
        idx     = IW'(k);
      end
    end
  end

  seg_to_bcd u_dec (
    .seg     (sync2[6:0]),
    .digit   (dec_digit),
    .illegal (dec_illegal)
  );

  assign capture   = eval && (low_cnt == LW'(1));
  assign seen_full = &seen;

  // Completion clears seen on the edge after it fills; a capture on that
  // same edge seeds the next frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slots       <= '0;
      err         <= '0;
      seen        <= '0;
      value       <= '0;
      digit_error <= '0;
      frame_valid <= 1'b0;
    end else begin
      if (capture) begin
        slots[idx] <= dec_digit;
        err[idx]   <= dec_illegal;
      end
      seen        <= (seen_full ? '0 : seen) |
                     (capture ? (DIGITS'(1) << idx) : '0);
      frame_valid <= seen_full;
      if (seen_full) begin
        value       <= slots;
        digit_error <= err;
      end
    end
  end

endmodule

// File: tb/tb_segment_scan_reader.sv
module tb_segment_scan_reader;

  localparam int D = 4;
  localparam int S = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  anodes = 4'hF;
  logic [6:0]  segments = 7'h7F;
  logic [15:0] value;
  logic [3:0]  digit_error;
  logic        frame_valid;

  segment_scan_reader #(.DIGITS(D), .STABLE_CYCLES(S)) dut (
    .clk         (clk),
    .reset       (reset),
    .anodes      (anodes),
    .segments    (segments),
    .value       (value),
    .digit_error (digit_error),
    .frame_valid (frame_valid)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [6:0] codes [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                             7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                             7'b0000000, 7'b0011000};

  // reference model: frame contents and scheduled frame_valid pulses
  logic [3:0]  m_slot [4];
  logic [3:0]  m_err, m_seen, m_derr;
  logic [15:0] m_val;
  logic [10:0] last_in;
  int          pq_cyc [$];
  logic [15:0] pq_val [$];
  logic [3:0]  pq_err [$];

  function automatic logic [3:0] ref_dec(input logic [6:0] s);
    for (int i = 0; i < 10; i++) if (codes[i] == s) return 4'(i);
    return 4'hF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 4; i++) m_slot[i] = 4'h0;
    m_err = '0; m_seen = '0; m_val = '0; m_derr = '0;
    pq_cyc.delete(); pq_val.delete(); pq_err.delete();
  endtask

  // one clock: sample 1 time unit after the edge, compare against the model
  task automatic tick();
    logic exp_fv;
    @(posedge clk);
    cyc++;
    #1;
    exp_fv = (pq_cyc.size() > 0) && (pq_cyc[0] == cyc);
    if (exp_fv) begin
      void'(pq_cyc.pop_front());
      m_val  = pq_val.pop_front();
      m_derr = pq_err.pop_front();
    end
    chk("frame_valid", 32'(frame_valid), 32'(exp_fv));
    chk("value", 32'(value), 32'(m_val));
    chk("digit_error", 32'(digit_error), 32'(m_derr));
  endtask

  // present one bus pattern for n cycles; a pattern that differs from the
  // previous one and is held n >= S+1 cycles is captured at edge start+S+3
  task automatic seg(input logic [3:0] an, input logic [6:0] sg, input int n);
    int k;
    logic [3:0] d;
    anodes = an;
    segments = sg;
    if (n >= S + 1 && {an, sg} != last_in && $countones(~an) == 1) begin
      k = 0;
      for (int i = 0; i < 4; i++) if (!an[i]) k = i;
      d = ref_dec(sg);
      m_slot[k] = d;
      m_err[k]  = (d == 4'hF);
      m_seen[k] = 1'b1;
      if (m_seen == 4'hF) begin
        pq_cyc.push_back(cyc + S + 4);
        pq_val.push_back({m_slot[3], m_slot[2], m_slot[1], m_slot[0]});
        pq_err.push_back(m_err);
        m_seen = '0;
      end
    end
    last_in = {an, sg};
    repeat (n) tick();
  endtask

  task automatic digit(input int k, input int v, input int n);
    seg(~(4'(1) << k), codes[v], n);
  endtask

  initial begin
    logic [3:0] an;
    logic [6:0] sg;
    int k, r, n;

    model_clear();
    last_in = 11'h7FF;
    #1;
    chk("reset_value", 32'(value), 32'h0);
    chk("reset_err", 32'(digit_error), 32'h0);
    chk("reset_fv", 32'(frame_valid), 32'h0);
    tick(); tick();
    reset = 1'b0;
    seg(4'hF, 7'h7F, 3);

    // basic scan -> 4321
    seg(4'b1110, 7'b1111001, 8);
    seg(4'b1101, 7'b0100100, 8);
    seg(4'b1011, 7'b0110000, 8);
    seg(4'b0111, 7'b0011001, 8);
    seg(4'hF, 7'h7F, 4);
    chk("scan_value", 32'(value), 32'h4321);
    chk("scan_err", 32'(digit_error), 32'h0);

    // glitch: 3-cycle patterns are never captured; 100-cycle hold only once
    digit(0, 6, 3); digit(0, 7, 3); digit(1, 8, 3);
    digit(0, 1, 8); digit(1, 1, 8); digit(2, 1, 8);
    digit(3, 2, 100);
    digit(0, 3, 8); digit(1, 3, 8); digit(2, 3, 8);
    seg(4'hF, 7'h7F, 6);
    chk("glitch_value", 32'(value), 32'h2111);

    // illegal code on digit 2
    digit(0, 5, 8); digit(1, 0, 8);
    seg(4'b1011, 7'b1111111, 8);
    digit(3, 9, 8);
    seg(4'hF, 7'h7F, 4);
    chk("illegal_value", 32'(value), 32'h9F05);
    chk("illegal_err", 32'(digit_error), 32'h4);

    // blanking and ghosting between digits, plus overwrite of digit 0
    digit(0, 7, 8); seg(4'hF, 7'h7F, 10);
    digit(0, 8, 8); seg(4'b1100, codes[3], 10);
    digit(1, 6, 8); seg(4'hF, 7'h7F, 10);
    digit(2, 4, 8); seg(4'b1100, codes[2], 10);
    digit(3, 1, 8); seg(4'hF, 7'h7F, 4);
    chk("overwrite_value", 32'(value), 32'h1468);

    // continuous scanning
    for (int f = 0; f < 3; f++)
      for (int j = 0; j < 4; j++) digit(j, (f + j) % 10, 6);
    seg(4'hF, 7'h7F, 8);
    chk("cont_value", 32'(value), 32'h5432);

    // async reset after two digits captured
    digit(0, 9, 8); digit(1, 9, 8);
    seg(4'hF, 7'h7F, 10);
    #2 reset = 1'b1;
    anodes = 4'hF; segments = 7'h7F;
    #1;
    model_clear();
    last_in = 11'h7FF;
    chk("rst_value", 32'(value), 32'h0);
    chk("rst_err", 32'(digit_error), 32'h0);
    chk("rst_fv", 32'(frame_valid), 32'h0);
    tick(); tick();
    reset = 1'b0;
    seg(4'hF, 7'h7E, 3);
    digit(2, 7, 8); digit(3, 7, 8);
    seg(4'hF, 7'h7F, 10);
    chk("rst_partial", 32'(value), 32'h0);
    digit(0, 6, 8); digit(1, 5, 8);
    seg(4'hF, 7'h7F, 4);
    chk("rst_recapture", 32'(value), 32'h7756);

    // randomized bus traffic
    repeat (300) begin
      r = $urandom_range(0, 9);
      k = $urandom_range(0, 3);
      sg = codes[$urandom_range(0, 9)];
      an = ~(4'(1) << k);
      if (r == 7) sg = 7'($urandom);
      else if (r == 8) an = 4'hF;
      else if (r == 9) an = ~((4'(1) << k) | (4'(1) << ((k + 1 + $urandom_range(0, 2)) % 4)));
      if ({an, sg} == last_in) sg = sg ^ 7'h01;
      n = $urandom_range(1, 2 * S + 3);
      seg(an, sg, n);
    end
    seg(4'hF, 7'h7F, 12);
    chk("pending_pulses", 32'(pq_cyc.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
